// File: rtl/seg_display_scanner.sv
// ---------------------------------------------------------------------------
// seg_display_scanner
//
// Time-multiplexed driver for a common-segment LED display. One digit is
// refreshed per slot, and an internal prescaler sets the slot length. The
// block also provides:
//   - brightness PWM on the digit enables,
//   - anti-ghost blanking at the start of every slot,
//   - per-digit masking,
//   - double-buffered (shadow/active) frames, so a displayed frame is never
//     a mix of old and new codes.
//
// Ports
//   clock       system clock
//   reset       synchronous, active-low
//   seg_in      digit i segment code at [i*SEG_W +: SEG_W], 1 = lit
//   dp_in       decimal point per digit, 1 = lit
//   load        one-clock strobe: capture seg_in/dp_in into the shadow frame
//   digit_mask  1 = digit enabled, sampled every clock
//   brightness  PWM duty, 0 = dark, all-ones = full on
//   seg_out     segment drive for the current digit
//   dp_out      decimal-point drive for the current digit
//   en_out      one-hot digit enable
//   frame_done  one-clock pulse when the last slot of a frame ends
// ---------------------------------------------------------------------------
module seg_display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int SEG_W       = 7,
    parameter int PRESCALE    = 50000,
    parameter int BLANK       = 16,
    parameter int DUTY_W      = 4,
    parameter int SEG_ACT_LOW = 0,
    parameter int EN_ACT_LOW  = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic                        load,
    input  logic [NUM_DIGITS-1:0]       digit_mask,
    input  logic [DUTY_W-1:0]           brightness,
    output logic [SEG_W-1:0]            seg_out,
    output logic                        dp_out,
    output logic [NUM_DIGITS-1:0]       en_out,
    output logic                        frame_done
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DIG_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK);
    localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]  prescaler;
    logic [DIG_W-1:0]  digit;
    logic [DUTY_W-1:0] phase;

    logic [SEG_W-1:0]  shadow_seg [NUM_DIGITS];
    logic [SEG_W-1:0]  active_seg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [NUM_DIGITS-1:0] active_dp;
    logic              pending;

    logic [SEG_W-1:0]      seg_r;
    logic                  dp_r;
    logic [NUM_DIGITS-1:0] en_r;
    logic                  frame_done_r;

    logic                  slot_end;
    logic                  frame_wrap;
    logic                  lit;
    logic [NUM_DIGITS-1:0] en_next;

    assign slot_end   = (prescaler == CNT_LAST);
    assign frame_wrap = slot_end && (digit == DIG_LAST);

    // All-ones brightness is forced on; otherwise the phase comparison alone
    // would leave one dark clock per PWM period.
    assign lit = (brightness == {DUTY_W{1'b1}}) || (phase < brightness);

    // At most one enable can be set, and only for the current digit, so the
    // enables cannot overlap even across a slot change.
    always_comb begin
        en_next = '0;
        if (digit_mask[digit] && lit && (prescaler >= BLANK_END)) begin
            en_next[digit] = 1'b1;
        end
    end

    // Slot pacing, digit scan and free-running PWM phase.
    always_ff @(posedge clock) begin
        if (!reset) begin
            prescaler <= '0;
            digit     <= '0;
            phase     <= '0;
        end else begin
            phase <= phase + 1'b1;
            if (slot_end) begin
                prescaler <= '0;
                digit     <= (digit == DIG_LAST) ? '0 : digit + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
        end
    end

    // Frame buffering. The active frame only changes on the frame wrap, and
    // it takes the shadow contents from before this clock's load. A load on
    // the wrap clock therefore stays pending until the following wrap.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_seg[i] <= '0;
                active_seg[i] <= '0;
            end
            shadow_dp <= '0;
            active_dp <= '0;
            pending   <= 1'b0;
        end else begin
            if (frame_wrap && pending) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    active_seg[i] <= shadow_seg[i];
                end
                active_dp <= shadow_dp;
            end
            if (load) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    shadow_seg[i] <= seg_in[i*SEG_W +: SEG_W];
                end
                shadow_dp <= dp_in;
                pending   <= 1'b1;
            end else if (frame_wrap) begin
                pending <= 1'b0;
            end
        end
    end

    // Output registers, computed from this clock's counter state.
    always_ff @(posedge clock) begin
        if (!reset) begin
            seg_r        <= '0;
            dp_r         <= 1'b0;
            en_r         <= '0;
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= active_seg[digit];
            dp_r         <= active_dp[digit];
            en_r         <= en_next;
            frame_done_r <= frame_wrap;
        end
    end

    // Pin polarity is applied after the registers, so reset drives the
    // inactive level at the pins in both polarities.
    assign seg_out    = (SEG_ACT_LOW != 0) ? ~seg_r : seg_r;
    assign dp_out     = (SEG_ACT_LOW != 0) ? ~dp_r  : dp_r;
    assign en_out     = (EN_ACT_LOW  != 0) ? ~en_r  : en_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_seg_display_scanner
//
// Drives an active-high-polarity instance and an inverted-polarity instance
// with the same inputs. A time-based reference model predicts every output
// on every clock, and directed checks with hand-computed literals cover scan
// order, blanking, PWM, masking, frame loading and reset.
// ---------------------------------------------------------------------------
module tb_seg_display_scanner;

    localparam int ND = 4;
    localparam int SW = 7;
    localparam int PS = 8;
    localparam int BL = 2;
    localparam int DW = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [ND*SW-1:0]  seg_in = '0;
    logic [ND-1:0]     dp_in = '0;
    logic              load = 1'b0;
    logic [ND-1:0]     digit_mask = '1;
    logic [DW-1:0]     brightness = '1;

    logic [SW-1:0]     seg_out, seg_out_inv;
    logic              dp_out, dp_out_inv;
    logic [ND-1:0]     en_out, en_out_inv;
    logic              frame_done, frame_done_inv;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    seg_display_scanner #(
        .NUM_DIGITS(ND), .SEG_W(SW), .PRESCALE(PS), .BLANK(BL), .DUTY_W(DW),
        .SEG_ACT_LOW(0), .EN_ACT_LOW(0)
    ) dut (
        .clock(clock), .reset(reset), .seg_in(seg_in), .dp_in(dp_in),
        .load(load), .digit_mask(digit_mask), .brightness(brightness),
        .seg_out(seg_out), .dp_out(dp_out), .en_out(en_out),
        .frame_done(frame_done)
    );

    seg_display_scanner #(
        .NUM_DIGITS(ND), .SEG_W(SW), .PRESCALE(PS), .BLANK(BL), .DUTY_W(DW),
        .SEG_ACT_LOW(1), .EN_ACT_LOW(1)
    ) dut_inv (
        .clock(clock), .reset(reset), .seg_in(seg_in), .dp_in(dp_in),
        .load(load), .digit_mask(digit_mask), .brightness(brightness),
        .seg_out(seg_out_inv), .dp_out(dp_out_inv), .en_out(en_out_inv),
        .frame_done(frame_done_inv)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Reference model: time since reset gives slot position, digit and PWM
    // phase directly; frames are kept as per-digit arrays.
    logic [SW-1:0] m_shadow_seg [ND];
    logic [SW-1:0] m_active_seg [ND];
    logic          m_shadow_dp  [ND];
    logic          m_active_dp  [ND];
    logic          m_pending;
    int            m_time;
    logic [SW-1:0] exp_seg;
    logic          exp_dp;
    logic [ND-1:0] exp_en;
    logic          exp_fd;
    logic          model_valid = 1'b0;

    always @(posedge clock) begin : model
        int   p;
        int   d;
        int   ph;
        logic on;
        logic wrap;
        model_valid <= 1'b1;
        if (!reset) begin
            m_time    <= 0;
            m_pending <= 1'b0;
            for (int i = 0; i < ND; i++) begin
                m_shadow_seg[i] <= '0;
                m_active_seg[i] <= '0;
                m_shadow_dp[i]  <= 1'b0;
                m_active_dp[i]  <= 1'b0;
            end
            exp_seg <= '0;
            exp_dp  <= 1'b0;
            exp_en  <= '0;
            exp_fd  <= 1'b0;
        end else begin
            p    = m_time % PS;
            d    = (m_time / PS) % ND;
            ph   = m_time % (1 << DW);
            on   = (int'(brightness) == (1 << DW) - 1) || (ph < int'(brightness));
            wrap = (p == PS - 1) && (d == ND - 1);
            exp_seg <= m_active_seg[d];
            exp_dp  <= m_active_dp[d];
            exp_en  <= (digit_mask[d] && on && p >= BL) ? (ND'(1) << d) : '0;
            exp_fd  <= wrap;
            if (wrap && m_pending) begin
                for (int i = 0; i < ND; i++) begin
                    m_active_seg[i] <= m_shadow_seg[i];
                    m_active_dp[i]  <= m_shadow_dp[i];
                end
            end
            if (load) begin
                for (int i = 0; i < ND; i++) begin
                    m_shadow_seg[i] <= seg_in[i*SW +: SW];
                    m_shadow_dp[i]  <= dp_in[i];
                end
                m_pending <= 1'b1;
            end else if (wrap) begin
                m_pending <= 1'b0;
            end
            m_time <= m_time + 1;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (model_valid) begin
            checkOutput("model_normal",
                        {19'd0, seg_out, dp_out, en_out, frame_done},
                        {19'd0, exp_seg, exp_dp, exp_en, exp_fd});
            checkOutput("model_inverted",
                        {19'd0, seg_out_inv, dp_out_inv, en_out_inv, frame_done_inv},
                        {19'd0, ~exp_seg, ~exp_dp, ~exp_en, exp_fd});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ld,
                                 input logic [ND*SW-1:0] s, input logic [ND-1:0] dp,
                                 input logic [ND-1:0] mask, input logic [DW-1:0] br);
        reset      = rst;
        load       = ld;
        seg_in     = s;
        dp_in      = dp;
        digit_mask = mask;
        brightness = br;
        tick(1);
        load = 1'b0;
    endtask

    task automatic waitFrameDone(input string name, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (frame_done !== 1'b1 && n < 100);
        if (frame_done !== 1'b1) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout actual=no frame_done required=pulse within 100 clocks", name);
        end
    endtask

    initial begin
        logic [ND*SW-1:0] code_a, code_b, code_c;
        logic [SW-1:0]    a_code [ND];
        logic [SW-1:0]    b_code [ND];
        logic [SW-1:0]    c_code [ND];
        logic [ND-1:0]    dp_a, dp_b;
        int               n, fd_cnt, fd_at, total, off02, on1, on3;
        int               on_cnt [ND];

        code_a = {7'h5B, 7'h4F, 7'h66, 7'h06};
        code_b = {7'h07, 7'h7F, 7'h6D, 7'h3F};
        code_c = {7'h71, 7'h79, 7'h5E, 7'h39};
        a_code[0] = 7'h06; a_code[1] = 7'h66; a_code[2] = 7'h4F; a_code[3] = 7'h5B;
        b_code[0] = 7'h3F; b_code[1] = 7'h6D; b_code[2] = 7'h7F; b_code[3] = 7'h07;
        c_code[0] = 7'h39; c_code[1] = 7'h5E; c_code[2] = 7'h79; c_code[3] = 7'h71;
        dp_a = 4'b0101;
        dp_b = 4'b1010;

        // Reset levels for both polarities.
        applyStimulus(1'b0, 1'b0, '0, '0, 4'hF, 4'hF);
        tick(2);
        checkOutput("reset_en", en_out, 4'h0);
        checkOutput("reset_seg", seg_out, 7'h00);
        checkOutput("reset_fd", frame_done, 1'b0);
        checkOutput("reset_inv_en", en_out_inv, 4'hF);
        checkOutput("reset_inv_seg", seg_out_inv, 7'h7F);
        checkOutput("reset_inv_dp", dp_out_inv, 1'b1);

        // Load frame A on the first active clock; it appears after the wrap.
        applyStimulus(1'b1, 1'b1, code_a, dp_a, 4'hF, 4'hF);
        waitFrameDone("first_frame_done", n);
        checkOutput("first_frame_done_latency", n, 31);

        for (int d = 0; d < ND; d++) on_cnt[d] = 0;
        fd_cnt = 0;
        fd_at  = -1;
        for (int i = 0; i < 32; i++) begin
            tick(1);
            if (en_out[i / 8]) on_cnt[i / 8]++;
            if (frame_done) begin
                fd_cnt++;
                fd_at = i;
            end
            if (i % 8 == 4) begin
                checkOutput($sformatf("slot%0d_seg", i / 8), seg_out, a_code[i / 8]);
                checkOutput($sformatf("slot%0d_dp", i / 8), dp_out, dp_a[i / 8]);
                checkOutput($sformatf("slot%0d_en", i / 8), en_out, 4'(1) << (i / 8));
            end
        end
        for (int d = 0; d < ND; d++) begin
            checkOutput($sformatf("slot%0d_on_clocks", d), on_cnt[d], 6);
        end
        checkOutput("frame_done_count", fd_cnt, 1);
        checkOutput("frame_done_position", fd_at, 31);

        // Reset in the middle of slot 2.
        tick(19);
        checkOutput("mid_slot2_en", en_out, 4'b0100);
        reset = 1'b0;
        tick(1);
        checkOutput("reset_mid_slot_en", en_out, 4'h0);
        checkOutput("reset_mid_slot_seg", seg_out, 7'h00);
        checkOutput("reset_mid_slot_inv_en", en_out_inv, 4'hF);
        reset = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (en_out == 4'h0 && n < 20);
        checkOutput("restart_latency", n, 3);
        checkOutput("restart_digit", en_out, 4'b0001);

        // Mid-frame load keeps the old frame until the wrap.
        applyStimulus(1'b1, 1'b1, code_a, dp_a, 4'hF, 4'hF);
        waitFrameDone("frame_a_apply", n);
        tick(12);
        applyStimulus(1'b1, 1'b1, code_b, dp_b, 4'hF, 4'hF);
        tick(16);
        checkOutput("old_frame_kept", seg_out, a_code[3]);
        waitFrameDone("frame_b_apply", n);
        checkOutput("frame_b_wrap_latency", n, 3);
        tick(5);
        checkOutput("new_frame_digit0", seg_out, b_code[0]);
        tick(16);
        checkOutput("new_frame_digit2", seg_out, b_code[2]);
        checkOutput("new_frame_dp2", dp_out, dp_b[2]);

        // Load on the wrap clock is deferred to the following wrap.
        tick(10);
        applyStimulus(1'b1, 1'b1, code_c, dp_a, 4'hF, 4'hF);
        tick(4);
        checkOutput("load_on_wrap_deferred", seg_out, b_code[0]);
        waitFrameDone("frame_c_apply", n);
        tick(5);
        checkOutput("load_on_wrap_applied", seg_out, c_code[0]);

        // Repeated loads: the last one wins.
        tick(2);
        applyStimulus(1'b1, 1'b1, code_a, dp_a, 4'hF, 4'hF);
        applyStimulus(1'b1, 1'b1, code_b, dp_b, 4'hF, 4'hF);
        waitFrameDone("last_load_apply", n);
        tick(5);
        checkOutput("last_load_wins", seg_out, b_code[0]);

        // Brightness 4 and 0.
        applyStimulus(1'b1, 1'b0, code_b, dp_b, 4'hF, 4'd4);
        total = 0;
        for (int i = 0; i < 32; i++) begin
            tick(1);
            if (en_out != 4'h0) total++;
        end
        checkOutput("bright4_on_clocks", total, 4);
        applyStimulus(1'b1, 1'b0, code_b, dp_b, 4'hF, 4'd0);
        total = 0;
        for (int i = 0; i < 32; i++) begin
            tick(1);
            if (en_out != 4'h0) total++;
        end
        checkOutput("bright0_on_clocks", total, 0);

        // Digit mask 1010.
        applyStimulus(1'b1, 1'b0, code_b, dp_b, 4'b1010, 4'hF);
        off02  = 0;
        on1    = 0;
        on3    = 0;
        fd_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            tick(1);
            if (en_out[0] || en_out[2]) off02++;
            if (en_out[1]) on1++;
            if (en_out[3]) on3++;
            if (frame_done) fd_cnt++;
        end
        checkOutput("mask_bits02_off", off02, 0);
        checkOutput("mask_bit1_on", on1, 12);
        checkOutput("mask_bit3_on", on3, 12);
        checkOutput("mask_frame_done_count", fd_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
